// File: rtl/pmem_burst_adapter.sv
// Cache-line to DRAM burst adapter: one LINE_WIDTH read or write from the cache
// pmem port is executed as BEATS consecutive BEAT_WIDTH beats on the burst port.
module pmem_burst_adapter #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [31:0]           pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [31:0]           burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    if (LINE_WIDTH % BEAT_WIDTH != 0) begin : g_bad_width
        $error("LINE_WIDTH must be a multiple of BEAT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [IDX_W-1:0]      beat_idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  last_beat;
    logic [LINE_WIDTH-1:0] line_buf;
    logic [LINE_WIDTH-1:0] read_line;
    logic [31:0]           line_addr;
    logic                  unused_addr_bits;

    assign line_addr        = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^pmem_address[OFF_W-1:0];
    assign beat_idx         = beat_cnt[IDX_W-1:0];
    assign next_idx         = beat_idx + 1'b1;
    assign last_beat        = (beat_cnt == CNT_W'(BEATS - 1));

    // Line buffer with the current read beat merged in, so the final beat can
    // be published to pmem_rdata in the same edge that completes the burst.
    always_comb begin
        read_line = line_buf;
        read_line[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
    end

    // Shared staging buffer: holds the write line, or assembles the read line.
    always_ff @(posedge clk) begin
        if (state == IDLE && pmem_write) begin
            line_buf <= pmem_wdata;
        end else if (state == READ && burst_resp) begin
            line_buf <= read_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            pmem_rdata    <= '0;
            pmem_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= '0;
            burst_wdata   <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pmem_write) begin
                        state         <= WRITE;
                        burst_write   <= 1'b1;
                        burst_address <= line_addr;
                        burst_wdata   <= pmem_wdata[BEAT_WIDTH-1:0];
                    end else if (pmem_read) begin
                        state         <= READ;
                        burst_read    <= 1'b1;
                        burst_address <= line_addr;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state      <= DONE;
                            burst_read <= 1'b0;
                            pmem_resp  <= 1'b1;
                            pmem_rdata <= read_line;
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state       <= DONE;
                            burst_write <= 1'b0;
                            pmem_resp   <= 1'b1;
                        end else begin
                            burst_wdata <= line_buf[next_idx*BEAT_WIDTH +: BEAT_WIDTH];
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Bench for pmem_burst_adapter: directed scenarios plus randomized line
// transfers checked against a transaction-level expectation of each burst.
module tb_pmem_burst_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [255:0] exp_rdata;

    pmem_burst_adapter #(.LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cache transaction. pat/plen give the burst_resp sequence (bit i = cycle i
    // of the burst); plen == 0 selects random gaps. The request stays asserted
    // through the pmem_resp cycle and into the following IDLE cycle.
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [255:0] line, input logic [15:0] pat, input int plen);
        int          acc;
        int          cyc;
        bit          r;
        logic [31:0] exp_addr;
        exp_addr     = {addr[31:5], 5'b0};
        pmem_write   = wr;
        pmem_read    = rd;
        pmem_address = addr;
        pmem_wdata   = wr ? line : {8{$urandom}};
        burst_resp   = 1'b0;
        tick();
        acc = 0;
        cyc = 0;
        while (acc < 4 && cyc < 64) begin
            if (wr) begin
                check("burst_write_high", burst_write, 1);
                check("burst_read_low_in_write", burst_read, 0);
                check("burst_wdata", burst_wdata, line[acc*64 +: 64]);
            end else begin
                check("burst_read_high", burst_read, 1);
                check("burst_write_low_in_read", burst_write, 0);
            end
            check("burst_address", burst_address, exp_addr);
            check("no_early_resp", pmem_resp, 0);
            check("rdata_held_during_burst", pmem_rdata, exp_rdata);
            r = (plen == 0) ? ($urandom_range(0, 2) != 0) : pat[cyc];
            burst_resp  = r;
            burst_rdata = (r && !wr) ? line[acc*64 +: 64] : {$urandom, $urandom};
            tick();
            if (r) acc++;
            cyc++;
        end
        burst_resp  = 1'($urandom_range(0, 1));
        burst_rdata = {$urandom, $urandom};
        if (!wr) exp_rdata = line;
        check("pmem_resp_pulse", pmem_resp, 1);
        check("done_burst_read", burst_read, 0);
        check("done_burst_write", burst_write, 0);
        check("pmem_rdata", pmem_rdata, exp_rdata);
        tick();
        burst_resp = 1'b0;
        check("resp_one_cycle", pmem_resp, 0);
        check("idle_burst_read", burst_read, 0);
        check("idle_burst_write", burst_write, 0);
    endtask

    task automatic drop_req();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        burst_resp = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line;
        logic [31:0]  addr;
        bit           wr;
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        exp_rdata    = '0;
        tick();
        tick();
        check("rst_pmem_rdata", pmem_rdata, 0);
        check("rst_pmem_resp", pmem_resp, 0);
        check("rst_burst_read", burst_read, 0);
        check("rst_burst_write", burst_write, 0);
        check("rst_burst_address", burst_address, 0);
        check("rst_burst_wdata", burst_wdata, 0);
        rst = 1'b0;
        tick();

        // Read with back-to-back beats.
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_txn(1'b0, 1'b1, 32'h0000_1234, line, 16'h000F, 4);
        drop_req();

        // Write with gaps 1,0,1,0,0,1,1, followed immediately by a read.
        line = {64'hD, 64'hC, 64'hB, 64'hA};
        do_txn(1'b1, 1'b0, 32'h8000_0040, line, 16'h0065, 7);
        line = {8{$urandom}};
        do_txn(1'b0, 1'b1, 32'h0000_2000, line, 16'h000F, 4);
        drop_req();

        // Simultaneous read and write: write first, then the still-held read.
        line = {8{$urandom}};
        do_txn(1'b1, 1'b1, 32'h0000_3000, line, 16'h000F, 4);
        line = {8{$urandom}};
        do_txn(1'b0, 1'b1, 32'h0000_3000, line, 16'h001B, 5);
        drop_req();

        // Reset after two read beats, then a clean full read.
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_4000;
        tick();
        burst_resp  = 1'b1;
        burst_rdata = {$urandom, $urandom};
        tick();
        burst_rdata = {$urandom, $urandom};
        tick();
        rst = 1'b1;
        tick();
        check("midrst_burst_read", burst_read, 0);
        check("midrst_pmem_resp", pmem_resp, 0);
        check("midrst_pmem_rdata", pmem_rdata, 0);
        check("midrst_burst_address", burst_address, 0);
        exp_rdata = '0;
        rst = 1'b0;
        drop_req();
        line = {8{$urandom}};
        do_txn(1'b0, 1'b1, 32'h0000_4000, line, 16'h000F, 4);
        drop_req();

        // Stray burst_resp while idle must be ignored.
        for (int i = 0; i < 6; i++) begin
            burst_resp  = 1'($urandom_range(0, 1));
            burst_rdata = {$urandom, $urandom};
            tick();
            check("stray_no_resp", pmem_resp, 0);
            check("stray_no_burst_read", burst_read, 0);
            check("stray_no_burst_write", burst_write, 0);
        end
        line = {8{$urandom}};
        do_txn(1'b0, 1'b1, 32'h0000_5010, line, 16'h000F, 4);
        drop_req();

        // Randomized mix with random gaps and idle spacing.
        for (int t = 0; t < 24; t++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom;
            line = {8{$urandom}};
            do_txn(wr, !wr, addr, line, 16'h0000, 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) drop_req();
        end
        drop_req();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pmem_burst_adapter.md
Name: pmem_burst_adapter

Overview:
- Physical-memory-side responder for the L1 cache's pmem_* initiator port.
- Accepts one 256-bit line read or write per request and executes it as a 4-beat, 64-bit burst on the DRAM/arbiter burst interface.
- Returns pmem_resp once the whole line has transferred.
- Sits between the cache pmem port and the burst memory model or arbiter.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, burst data width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH = 4 (must divide exactly).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pmem_read  input  1  line read request from cache, held until pmem_resp
- pmem_write  input  1  line write request from cache, held until pmem_resp
- pmem_address  input  32  line address from cache
- pmem_wdata  input  256  line write data
- pmem_rdata  output  256  assembled read line
- pmem_resp  output  1  one-cycle completion pulse
- burst_read  output  1  burst read request
- burst_write  output  1  burst write request
- burst_address  output  32  line-aligned burst address
- burst_wdata  output  64  current write beat
- burst_rdata  input  64  current read beat
- burst_resp  input  1  beat valid / beat accepted

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE, beat counter 0. All outputs 0: pmem_rdata, pmem_resp, burst_read, burst_write, burst_address, burst_wdata.
- Reset mid-burst: same as above. The partial line is discarded, and no pmem_resp is issued for the aborted request.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - pmem_write=1: latch address and pmem_wdata, go to WRITE.
  - Else pmem_read=1: latch address, go to READ.
  - Both high at once (protocol-illegal): write is serviced, then the read is serviced on a later request.
- Latched address: burst_address = {pmem_address[31:5], 5'b0}. Low 5 bits are ignored. The address is held constant for the whole burst.
- READ:
  - burst_read=1 for the entire state.
  - Each cycle with burst_resp=1 stores burst_rdata into line bits [64*k+63:64*k], where k = beat counter, then increments k.
  - Beat 0 is the least-significant 64 bits.
  - Gaps (burst_resp=0) are allowed and do not advance k.
  - On the 4th beat, go to DONE; burst_read drops in DONE.
- WRITE:
  - burst_write=1 and burst_wdata = latched line beat k for the entire state.
  - Each cycle with burst_resp=1 advances k. On the 4th accepted beat, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; burst_read and burst_write are 0.
  - Return to IDLE next cycle, k reset to 0.
  - The cache drops its request in the cycle after pmem_resp, so IDLE does not re-accept it.
- pmem_rdata:
  - Valid in the DONE cycle of a read.
  - Held until the next read's DONE; unaffected by writes.
  - Beats are assembled into an internal buffer, so pmem_rdata never shows a partial line.
- burst_resp while in IDLE or DONE is ignored.
- pmem_read/pmem_write deasserting mid-burst is a protocol violation. The burst still completes and pmem_resp still pulses.
- Latency (request seen in IDLE at cycle 0):
  - burst_read/burst_write rise at cycle 1.
  - With back-to-back beats at cycles 1–4, pmem_resp occurs at cycle 5.
  - Each gap cycle adds one cycle.
- Throughput: one line per (BEATS + 2 + gap) cycles; the earliest next request is accepted in the IDLE cycle after DONE.
- Beat counter width: clog2(BEATS) + 1 bits. It must not wrap before DONE.

Test Plan:
- Read, no gaps: reset; pmem_read=1, pmem_address=0x0000_1234; at cycles 1–4 burst_resp=1 with burst_rdata = 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: burst_address=0x0000_1220 and burst_read=1 during cycles 1–4.
  - Required: pmem_resp=1 only at cycle 5, with pmem_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with gaps: pmem_write=1, pmem_address=0x8000_0040, pmem_wdata = {64'hD, 64'hC, 64'hB, 64'hA}; burst_resp pattern 1,0,1,0,0,1,1.
  - Required: burst_wdata sequence A, B, B, C, C, C, D.
  - Required: burst_write=1 throughout, then exactly one pmem_resp pulse, 3 cycles later than the no-gap case.
- Back-to-back write then read: after the write's pmem_resp, the cache drops pmem_write and raises pmem_read the next cycle.
  - Required: the read is accepted in that IDLE cycle and burst_read rises one cycle later.
  - Required: pmem_rdata is unchanged by the write.
- Reset mid-read: assert rst after 2 beats.
  - Required: next cycle burst_read=0, pmem_resp=0, pmem_rdata=0.
  - Required: a subsequent full read returns only the new 4 beats.
- Simultaneous pmem_read=1 and pmem_write=1: required burst_write=1 (write serviced first) and burst_read=0.
- Stray burst_resp=1 pulses while IDLE: required no state change, no pmem_resp, counter stays 0.
